alu_ctrl_decoder: RTL and testbench

// - Pipelined producer of the 3-bit ALU control code and operand-B select consumed by the ALU datapath.
// - Decodes opcode/funct3/funct7[5] of an RV32I instruction. One register stage with a valid/ready handshake on both sides.
// - Flags opcodes and funct3 values the ALU does not implement, and counts them in a saturating counter.

---
 rtl/alu_ctrl_decoder.sv | 195 +++++++++++++++++++
 tb/tb_alu_ctrl_decoder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_decoder.sv
// Pipelined RV32I ALU-control decoder: one output register stage with valid/ready on both sides.
// Optional 1-entry skid buffer enabled by defining ALU_DEC_SKID_EN (in_ready then comes straight from a flop).
module alu_ctrl_decoder #(
    parameter int unsigned CNT_W      = 8,
    parameter logic [2:0]  RESET_CTRL = 3'b000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       ALUControl,
    output logic             ALUSrc,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_count
);

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_RTYPE  = 7'b0110011,
        OP_ITYPE  = 7'b0010011
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

    logic [2:0] dec_ctrl;
    logic       dec_src;
    logic       dec_ill;

    logic             valid_q, valid_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic             src_q, src_d;
    logic             ill_q, ill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic in_fire;

    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    always_comb begin
        dec_ctrl = RESET_CTRL;
        dec_src  = 1'b0;
        dec_ill  = 1'b0;
        case (instr[6:0])
            OP_LOAD, OP_STORE: begin
                dec_ctrl = ALU_ADD;
                dec_src  = 1'b1;
            end
            OP_BRANCH: dec_ctrl = ALU_SUB;
            OP_JAL:    dec_ctrl = ALU_ADD;
            OP_RTYPE, OP_ITYPE: begin
                dec_src = (instr[6:0] == OP_ITYPE);
                case (instr[14:12])
                    3'b000: begin
                        // instr[30] selects sub only for register-register ops; for addi it is immediate data
                        if ((instr[6:0] == OP_RTYPE) && instr[30]) begin
                            dec_ctrl = ALU_SUB;
                        end else begin
                            dec_ctrl = ALU_ADD;
                        end
                    end
                    3'b010:  dec_ctrl = ALU_SLT;
                    3'b110:  dec_ctrl = ALU_OR;
                    3'b111:  dec_ctrl = ALU_AND;
                    default: begin
                        dec_ctrl = RESET_CTRL;
                        dec_src  = 1'b0;
                        dec_ill  = 1'b1;
                    end
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    assign in_fire = in_valid && in_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (in_fire && dec_ill && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

`ifdef ALU_DEC_SKID_EN
    logic       skid_valid_q, skid_valid_d;
    logic [2:0] skid_ctrl_q, skid_ctrl_d;
    logic       skid_src_q, skid_src_d;
    logic       skid_ill_q, skid_ill_d;
    logic       stage_open;

    assign in_ready   = !skid_valid_q;
    assign stage_open = !valid_q || out_ready;

    // Skid is only ever filled while the output is stalled, and in_ready is low while it is full,
    // so a skid drain never coincides with an input acceptance.
    always_comb begin
        valid_d      = valid_q;
        ctrl_d       = ctrl_q;
        src_d        = src_q;
        ill_d        = ill_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_src_d   = skid_src_q;
        skid_ill_d   = skid_ill_q;
        if (stage_open) begin
            if (skid_valid_q) begin
                valid_d      = 1'b1;
                ctrl_d       = skid_ctrl_q;
                src_d        = skid_src_q;
                ill_d        = skid_ill_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                valid_d = 1'b1;
                ctrl_d  = dec_ctrl;
                src_d   = dec_src;
                ill_d   = dec_ill;
            end else begin
                valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = dec_ctrl;
            skid_src_d   = dec_src;
            skid_ill_d   = dec_ill;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= RESET_CTRL;
            skid_src_q   <= 1'b0;
            skid_ill_q   <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_src_q   <= skid_src_d;
            skid_ill_q   <= skid_ill_d;
        end
    end
`else
    assign in_ready = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        src_d   = src_q;
        ill_d   = ill_q;
        if (in_fire) begin
            valid_d = 1'b1;
            ctrl_d  = dec_ctrl;
            src_d   = dec_src;
            ill_d   = dec_ill;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= RESET_CTRL;
            src_q   <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            src_q   <= src_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid     = valid_q;
    assign ALUControl    = ctrl_q;
    assign ALUSrc        = src_q;
    assign illegal       = ill_q;
    assign illegal_count = cnt_q;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// Self-checking bench for alu_ctrl_decoder: queue-based reference model plus directed vectors.
// Works for both builds (ALU_DEC_SKID_EN defined or not); a CNT_W=2 instance covers counter saturation.
module tb_alu_ctrl_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = '0;

    logic       in_ready, out_valid, ALUSrc, illegal;
    logic [2:0] ALUControl;
    logic [7:0] illegal_count;

    logic       in_ready2, out_valid2, ALUSrc2, illegal2;
    logic [2:0] ALUControl2;
    logic [1:0] illegal_count2;

`ifdef ALU_DEC_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    alu_ctrl_decoder #(.CNT_W(8), .RESET_CTRL(3'b000)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready), .ALUControl(ALUControl), .ALUSrc(ALUSrc),
        .illegal(illegal), .illegal_count(illegal_count)
    );

    alu_ctrl_decoder #(.CNT_W(2), .RESET_CTRL(3'b000)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2), .instr(instr),
        .out_valid(out_valid2), .out_ready(out_ready), .ALUControl(ALUControl2), .ALUSrc(ALUSrc2),
        .illegal(illegal2), .illegal_count(illegal_count2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] ctrl;
        logic       src;
        logic       ill;
    } exp_t;

    int total = 0;
    int bad = 0;

    exp_t q[$];
    exp_t out_log[$];
    int unsigned ill_seen = 0;
    int unsigned acc_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        op = w[6:0];
        f3 = w[14:12];
        e = '{ctrl: 3'b000, src: 1'b0, ill: 1'b1};
        if (op == 7'h03 || op == 7'h23) e = '{ctrl: 3'b000, src: 1'b1, ill: 1'b0};
        else if (op == 7'h63)           e = '{ctrl: 3'b001, src: 1'b0, ill: 1'b0};
        else if (op == 7'h6F)           e = '{ctrl: 3'b000, src: 1'b0, ill: 1'b0};
        else if (op == 7'h33 || op == 7'h13) begin
            e.src = (op == 7'h13);
            e.ill = 1'b0;
            if (f3 == 3'd0)      e.ctrl = (op == 7'h33 && w[30]) ? 3'b001 : 3'b000;
            else if (f3 == 3'd2) e.ctrl = 3'b101;
            else if (f3 == 3'd6) e.ctrl = 3'b011;
            else if (f3 == 3'd7) e.ctrl = 3'b010;
            else                 e = '{ctrl: 3'b000, src: 1'b0, ill: 1'b1};
        end
        return e;
    endfunction

    // Model: the decoder behaves as a FIFO of capacity 2 (skid) or 1 (no skid) whose head is the output.
    function automatic bit exp_ready();
        if (SKID) return q.size() < 2;
        return (q.size() == 0) || out_ready;
    endfunction

    function automatic logic [31:0] sat(input int unsigned n, input int unsigned mx);
        return (n > mx) ? mx : n;
    endfunction

    bit   m_rdy, m_ofire;
    exp_t m_e;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            ill_seen = 0;
        end else begin
            m_rdy   = exp_ready();
            m_ofire = (q.size() > 0) && out_ready;
            if (m_ofire) void'(q.pop_front());
            if (in_valid && m_rdy) begin
                m_e = ref_decode(instr);
                q.push_back(m_e);
                if (m_e.ill) ill_seen++;
                acc_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("in_ready", {31'b0, in_ready}, {31'b0, exp_ready()});
            check("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
            check("out_valid2", {31'b0, out_valid2}, {31'b0, q.size() > 0});
            if (q.size() > 0) begin
                check("ALUControl", {29'b0, ALUControl}, {29'b0, q[0].ctrl});
                check("ALUSrc", {31'b0, ALUSrc}, {31'b0, q[0].src});
                check("illegal", {31'b0, illegal}, {31'b0, q[0].ill});
            end
            check("illegal_count", {24'b0, illegal_count}, sat(ill_seen, 255));
            check("illegal_count_w2", {30'b0, illegal_count2}, sat(ill_seen, 3));
            if (out_valid && out_ready) out_log.push_back('{ctrl: ALUControl, src: ALUSrc, ill: illegal});
        end
    end

    task automatic send(input logic [31:0] w, input logic [2:0] c, input logic s, input logic il, input string nm);
        in_valid = 1'b1;
        instr    = w;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check({nm, ".valid"}, {31'b0, out_valid}, 32'd1);
        check({nm, ".ctrl"}, {29'b0, ALUControl}, {29'b0, c});
        check({nm, ".src"}, {31'b0, ALUSrc}, {31'b0, s});
        check({nm, ".ill"}, {31'b0, illegal}, {31'b0, il});
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        check("drain_timeout", q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned a0;
        int n;
        @(negedge clk);
        check("rst.out_valid", {31'b0, out_valid}, 32'd0);
        check("rst.ctrl", {29'b0, ALUControl}, 32'd0);
        check("rst.src", {31'b0, ALUSrc}, 32'd0);
        check("rst.ill", {31'b0, illegal}, 32'd0);
        check("rst.count", {24'b0, illegal_count}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;

        send(32'h002081B3, 3'b000, 1'b0, 1'b0, "add");
        send(32'h402081B3, 3'b001, 1'b0, 1'b0, "sub");
        send(32'h0020E1B3, 3'b011, 1'b0, 1'b0, "or");
        send(32'h0020A1B3, 3'b101, 1'b0, 1'b0, "slt");
        send(32'h0000A283, 3'b000, 1'b1, 1'b0, "lw");
        send(32'h00208463, 3'b001, 1'b0, 1'b0, "beq");
        send(32'hFFF00093, 3'b000, 1'b1, 1'b0, "addi");
        send(32'h0020F1B3, 3'b010, 1'b0, 1'b0, "and");
        send(32'h0010A093, 3'b101, 1'b1, 1'b0, "slti");
        send(32'h0020A023, 3'b000, 1'b1, 1'b0, "sw");
        send(32'h0000006F, 3'b000, 1'b0, 1'b0, "jal");
        send(32'h0020C1B3, 3'b000, 1'b0, 1'b1, "xor");
        check("xor.count", {24'b0, illegal_count}, 32'd1);
        send(32'h0020C1B3, 3'b000, 1'b0, 1'b1, "xor2");
        send(32'h0000007F, 3'b000, 1'b0, 1'b1, "badop");
        send(32'h002091B3, 3'b000, 1'b0, 1'b1, "sll");
        send(32'h00000000, 3'b000, 1'b0, 1'b1, "zero");
        check("sat.count8", {24'b0, illegal_count}, 32'd5);
        check("sat.count2", {30'b0, illegal_count2}, 32'd3);
        drain();

        // Back-pressure: out_ready low for 3 cycles while add then sub are offered.
        out_log.delete();
        @(posedge clk);
        #1 out_ready = 1'b0;
        a0 = acc_cnt;
        in_valid = 1'b1;
        instr    = 32'h002081B3;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (acc_cnt - a0 == 1) instr = 32'h402081B3;
            if (acc_cnt - a0 == 2) in_valid = 1'b0;
        end
        @(negedge clk);
        check("bp.accepted", acc_cnt - a0, SKID ? 32'd2 : 32'd1);
        check("bp.in_ready", {31'b0, in_ready}, 32'd0);
        check("bp.hold_ctrl", {29'b0, ALUControl}, 32'd0);
        check("bp.hold_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        n = 0;
        while (in_valid && n < 10) begin
            @(posedge clk);
            #1 n++;
            if (acc_cnt - a0 == 2) in_valid = 1'b0;
        end
        drain();
        check("bp.log_size", out_log.size(), 32'd2);
        if (out_log.size() == 2) begin
            check("bp.first", {27'b0, out_log[0]}, {27'b0, 3'b000, 1'b0, 1'b0});
            check("bp.second", {27'b0, out_log[1]}, {27'b0, 3'b001, 1'b0, 1'b0});
        end

        // Reset while the stage (and skid, if present) holds entries.
        @(posedge clk);
        #1 out_ready = 1'b0;
        in_valid = 1'b1;
        instr    = 32'h0020E1B3;
        @(posedge clk);
        #1 instr = 32'h0020C1B3;
        @(posedge clk);
        #1 in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("mrst.out_valid", {31'b0, out_valid}, 32'd0);
        check("mrst.count", {24'b0, illegal_count}, 32'd0);
        check("mrst.in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post.in_ready", {31'b0, in_ready}, 32'd1);
        check("post.out_valid", {31'b0, out_valid}, 32'd0);
        send(32'hFFF00093, 3'b000, 1'b1, 1'b0, "post_addi");
        send(32'h0020C1B3, 3'b000, 1'b0, 1'b1, "post_xor");
        check("post.count", {24'b0, illegal_count}, 32'd1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
